// File: rtl/gated_edge_counter.sv
// Gated rising-edge counter for the frequency meter: counts synchronised sig_in
// edges while enable is high and publishes the total on each gate close.
// Optional build macro FREQ_OVF_EN: saturating counter plus ovf_out port.
module gated_edge_counter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
`ifdef FREQ_OVF_EN
    output logic             ovf_out,
`endif
    output logic             busy
);

    // state    | meaning
    // DISARMED | after reset; waits for the first gate open, partial window discarded
    // IDLE     | armed, gate closed (en_d = 0)
    // COUNT    | armed, gate window in progress (en_d = 1)
    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_COUNT    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;
    logic                   s_sync;
    logic                   edge_det;
    logic                   en_d;
    logic                   gate_open;
    logic                   gate_close;
    logic                   publish;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       edge_ext;

    assign s_sync     = sync_q[SYNC_STAGES-1];
    assign edge_det   = s_sync & ~s_q;
    assign gate_open  = enable & ~en_d;
    assign gate_close = ~enable & en_d;
    assign edge_ext   = {{(CNT_W-1){1'b0}}, edge_det};
    assign busy       = en_d & (state_q != ST_DISARMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_q    <= 1'b0;
            en_d   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_q    <= s_sync;
            en_d   <= enable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DISARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        case (state_q)
            ST_DISARMED: if (gate_open) state_d = ST_COUNT;
            ST_IDLE:     if (gate_open) state_d = ST_COUNT;
            ST_COUNT: begin
                if (gate_close) begin
                    publish = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_DISARMED;
        endcase
    end

`ifdef FREQ_OVF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (gate_open) begin
            cnt_d = edge_ext;
            ovf_d = 1'b0;
        end else if (enable && edge_det) begin
            // clamp at full scale and remember that edges were dropped
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end
    end
`else
    always_comb begin
        cnt_d = cnt_q;
        if (gate_open) begin
            cnt_d = edge_ext;
        end else if (enable) begin
            cnt_d = cnt_q + edge_ext;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            count_valid <= publish;
            if (publish) count_out <= cnt_q;
        end
    end

`ifdef FREQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q   <= 1'b0;
            ovf_out <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (publish) ovf_out <= ovf_q;
        end
    end
`endif

endmodule

// File: tb/tb_gated_edge_counter.sv
// Directed bench for gated_edge_counter: a 32-bit instance and a 4-bit instance
// share all inputs; the 4-bit one is checked only for the overflow windows.
module tb_gated_edge_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sig_in;
    logic [31:0] count_out;
    logic        count_valid;
    logic        busy;
    logic [3:0]  count_out4;
    logic        count_valid4;
    logic        busy4;
`ifdef FREQ_OVF_EN
    logic        ovf_out;
    logic        ovf_out4;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gated_edge_counter #(.CNT_W(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .count_out(count_out), .count_valid(count_valid),
`ifdef FREQ_OVF_EN
        .ovf_out(ovf_out),
`endif
        .busy(busy)
    );

    gated_edge_counter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .count_out(count_out4), .count_valid(count_valid4),
`ifdef FREQ_OVF_EN
        .ovf_out(ovf_out4),
`endif
        .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Enable held high for ncyc cycles; sig_in rises every per cycles, nedges times.
    task automatic run_cycles(input int ncyc, input int nedges, input int per);
        for (int i = 0; i < ncyc; i++) begin
            enable = 1'b1;
            sig_in = ((i / per) < nedges) && ((i % per) < (per / 2));
            @(negedge clk);
        end
    endtask

    task automatic run_window(input int ncyc, input int nedges, input int per);
        run_cycles(ncyc, nedges, per);
        enable = 1'b0;
        sig_in = 1'b0;
    endtask

    // Called right after run_window: steps across the close edge and checks the report.
    task automatic close_check(input string tag, input logic armed, input logic [31:0] exp);
        check({tag, "_busy_pre"}, {31'd0, busy}, {31'd0, armed});
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, count_valid}, {31'd0, armed});
        if (armed) check({tag, "_count"}, count_out, exp);
        @(negedge clk);
        check({tag, "_valid_drop"}, {31'd0, count_valid}, 32'd0);
        check({tag, "_busy_post"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);

        // 1: reset state, then a 1000-cycle window with a 100 ns signal
        check("rst_count", count_out, 32'd0);
        check("rst_valid", {31'd0, count_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", {31'd0, count_valid}, 32'd0);
        run_window(1000, 100, 10);
        close_check("t1", 1'b1, 32'd100);

        // 2: reset released with enable already high; partial window discarded
        rst_n  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run_window(100, 5, 10);
        close_check("t2_partial", 1'b0, 32'd0);
        check("t2_count_held0", count_out, 32'd0);
        @(negedge clk);
        run_window(200, 12, 10);
        close_check("t2_full", 1'b1, 32'd12);

        // 3: no edges in a window
        run_window(200, 0, 10);
        close_check("t3", 1'b1, 32'd0);

        // 4: enable low for a single cycle between windows of 50 and 60 edges
        run_window(500, 50, 10);
        check("t4a_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t4a_valid", {31'd0, count_valid}, 32'd1);
        check("t4a_count", count_out, 32'd50);
        run_window(600, 60, 10);
        close_check("t4b", 1'b1, 32'd60);

        // 5: 20 edges overflow the 4-bit instance, then a small window
        run_window(250, 20, 10);
        @(negedge clk);
        check("t5_valid4", {31'd0, count_valid4}, 32'd1);
        check("t5_count32", count_out, 32'd20);
`ifdef FREQ_OVF_EN
        check("t5_count4_sat", {28'd0, count_out4}, 32'd15);
        check("t5_ovf4", {31'd0, ovf_out4}, 32'd1);
        check("t5_ovf32", {31'd0, ovf_out}, 32'd0);
`else
        check("t5_count4_wrap", {28'd0, count_out4}, 32'd4);
`endif
        @(negedge clk);
        run_window(50, 3, 10);
        @(negedge clk);
        check("t5b_count4", {28'd0, count_out4}, 32'd3);
`ifdef FREQ_OVF_EN
        check("t5b_ovf4", {31'd0, ovf_out4}, 32'd0);
`endif
        @(negedge clk);

        // 6: reset mid-window after 30 edges
        run_cycles(300, 30, 10);
        check("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", count_out, 32'd0);
        check("t6_rst_valid", {31'd0, count_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(20, 0, 10);
        close_check("t6_partial", 1'b0, 32'd0);
        @(negedge clk);
        run_window(100, 7, 10);
        close_check("t6_next", 1'b1, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
